// File: rtl/mmcm_ps_responder_pkg.sv
// Shared constants and state encoding for the MMCM phase-shift responder.
package mmcm_ps_responder_pkg;

    localparam int unsigned PS_STEPS_PER_VCO        = 56;
    localparam int unsigned PS_DONE_LATENCY_DEFAULT = 12;
    localparam int unsigned PS_CNT_W                = 8;

    typedef enum logic [1:0] {
        PSR_IDLE,
        PSR_BUSY,
        PSR_DONE
    } ps_resp_state_t;

endpackage

// File: rtl/mmcm_ps_responder_if.sv
// PSEN/PSINCDEC/PSDONE handshake between a phase-shift initiator and the MMCM (or its stand-in).
interface mmcm_ps_responder_if;

    logic ps_en;
    logic ps_incdec;
    logic ps_done;
    logic ps_busy;

    modport master (
        output ps_en,
        output ps_incdec,
        input  ps_done,
        input  ps_busy
    );

    modport slave (
        input  ps_en,
        input  ps_incdec,
        output ps_done,
        output ps_busy
    );

endinterface

// File: rtl/mmcm_ps_responder.sv
// Behavioural MMCM stand-in for the dynamic phase-shift port: fixed-latency PSDONE,
// phase position tracked modulo one output period, sticky overlap error.
module mmcm_ps_responder
    import mmcm_ps_responder_pkg::*;
#(
    parameter int unsigned DONE_LATENCY = PS_DONE_LATENCY_DEFAULT,
    parameter int unsigned PERIOD_STEPS = PS_STEPS_PER_VCO * 21,
    parameter int unsigned POS_W        = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmcm_ps_responder_if.slave   ps,
    input  logic                 err_clr_i,
    output logic [POS_W-1:0]     phase_pos_o,
    output logic                 wrap_o,
    output logic                 err_overlap_o,
    output logic [15:0]          shift_count_o
);

    localparam logic [PS_CNT_W-1:0] CntLoad = PS_CNT_W'(DONE_LATENCY - 1);
    localparam logic [POS_W:0]      PosMax  = (POS_W + 1)'(PERIOD_STEPS - 1);

    ps_resp_state_t      state_q, state_d;
    logic [PS_CNT_W-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic [15:0]         count_q, count_d;

    logic [POS_W:0]      pos_inc, pos_dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        count_d = count_q;

        // One guard bit so both wrap directions are detected explicitly.
        pos_inc = {1'b0, pos_q} + 1'b1;
        pos_dec = {1'b0, pos_q} - 1'b1;

        // Overlap set takes priority over a coincident clear.
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (ps.ps_en && (state_q != PSR_IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            PSR_IDLE: begin
                if (ps.ps_en) begin
                    dir_d   = ps.ps_incdec;
                    cnt_d   = CntLoad;
                    state_d = PSR_BUSY;
                end
            end
            PSR_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == PS_CNT_W'(1)) begin
                    state_d = PSR_DONE;
                    count_d = count_q + 16'd1;
                    if (dir_q) begin
                        if (pos_inc > PosMax) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_inc[POS_W-1:0];
                        end
                    end else begin
                        if (pos_dec[POS_W]) begin
                            pos_d  = PosMax[POS_W-1:0];
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_dec[POS_W-1:0];
                        end
                    end
                end
            end
            PSR_DONE: begin
                state_d = PSR_IDLE;
            end
            default: begin
                state_d = PSR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PSR_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign ps.ps_done    = (state_q == PSR_DONE);
    assign ps.ps_busy    = (state_q != PSR_IDLE);
    assign phase_pos_o   = pos_q;
    assign wrap_o        = wrap_q;
    assign err_overlap_o = err_q;
    assign shift_count_o = count_q;

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Scoreboard bench for mmcm_ps_responder: a 12-cycle and a 2-cycle latency instance.
module tb_mmcm_ps_responder;
    import mmcm_ps_responder_pkg::*;

    localparam int DL0   = 12;
    localparam int DL1   = 2;
    localparam int STEPS = 1176;

    typedef struct {
        int cyc;
        int pos;
        int wrap;
        int cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr0 = 1'b0, clr1 = 1'b0;
    logic [10:0] pos0, pos1;
    logic        wrap0, wrap1, err0, err1;
    logic [15:0] cnt0, cnt1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_pos[2];
    int   m_cnt[2];

    mmcm_ps_responder_if if0 ();
    mmcm_ps_responder_if if1 ();

    mmcm_ps_responder #(.DONE_LATENCY(DL0), .PERIOD_STEPS(STEPS), .POS_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n), .ps(if0), .err_clr_i(clr0), .phase_pos_o(pos0),
        .wrap_o(wrap0), .err_overlap_o(err0), .shift_count_o(cnt0)
    );

    mmcm_ps_responder #(.DONE_LATENCY(DL1), .PERIOD_STEPS(STEPS), .POS_W(11)) dut1 (
        .clk(clk), .rst_n(rst_n), .ps(if1), .err_clr_i(clr1), .phase_pos_o(pos1),
        .wrap_o(wrap1), .err_overlap_o(err1), .shift_count_o(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per ps_done; wrap must never pulse on its own.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n) begin
            if (if0.ps_done) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0 stray ps_done at cycle %0d, expected none", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("dut0 done cycle", cyc, e.cyc);
                    chk("dut0 phase_pos", 32'(pos0), e.pos);
                    chk("dut0 wrap", 32'(wrap0), e.wrap);
                    chk("dut0 shift_count", 32'(cnt0), e.cnt);
                end
            end else begin
                chk("dut0 wrap without ps_done", 32'(wrap0), 0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n) begin
            if (if1.ps_done) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1 stray ps_done at cycle %0d, expected none", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 done cycle", cyc, e.cyc);
                    chk("dut1 phase_pos", 32'(pos1), e.pos);
                    chk("dut1 wrap", 32'(wrap1), e.wrap);
                    chk("dut1 shift_count", 32'(cnt1), e.cnt);
                end
            end else begin
                chk("dut1 wrap without ps_done", 32'(wrap1), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic en, input logic inc);
        if (k == 0) begin
            if0.ps_en = en;
            if0.ps_incdec = inc;
        end else begin
            if1.ps_en = en;
            if1.ps_incdec = inc;
        end
    endtask

    // Accepted request: model the result and queue it, then pulse ps_en for one cycle.
    task automatic issue(input int k, input logic inc);
        exp_t e;
        int   w;
        w = 0;
        if (inc) begin
            if (m_pos[k] == STEPS - 1) begin
                m_pos[k] = 0;
                w = 1;
            end else begin
                m_pos[k] = m_pos[k] + 1;
            end
        end else begin
            if (m_pos[k] == 0) begin
                m_pos[k] = STEPS - 1;
                w = 1;
            end else begin
                m_pos[k] = m_pos[k] - 1;
            end
        end
        m_cnt[k] = (m_cnt[k] + 1) % 65536;
        e.cyc  = cyc + ((k == 0) ? DL0 : DL1);
        e.pos  = m_pos[k];
        e.wrap = w;
        e.cnt  = m_cnt[k];
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
        drive(k, 1'b1, inc);
        tick();
        drive(k, 1'b0, 1'b0);
    endtask

    // Request that must be ignored (overlap): no expectation queued.
    task automatic poke(input int k, input logic inc);
        drive(k, 1'b1, inc);
        tick();
        drive(k, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int k);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL dut%0d ps_done timeout: got none in 400 cycles, expected one", k);
            if (k == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        m_pos[0] = 0; m_pos[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish in 60000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        m_pos[0] = 0; m_pos[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        @(negedge clk);
        chk("reset ps_done", 32'(if0.ps_done), 0);
        chk("reset ps_busy", 32'(if0.ps_busy), 0);
        chk("reset phase_pos", 32'(pos0), 0);
        chk("reset wrap", 32'(wrap0), 0);
        chk("reset err_overlap", 32'(err0), 0);
        chk("reset shift_count", 32'(cnt0), 0);

        // Single increment at cycle 5; busy exactly for the 12 cycles that follow.
        while (cyc < r + 5) tick();
        c = cyc;
        chk("busy before request", 32'(if0.ps_busy), 0);
        issue(0, 1'b1);
        for (int i = 1; i <= DL0; i++) begin
            @(negedge clk);
            chk("busy during shift", 32'(if0.ps_busy), 1);
        end
        @(negedge clk);
        chk("busy after done", 32'(if0.ps_busy), 0);
        tick();
        wait_idle(0);
        chk("single shift phase_pos", 32'(pos0), 1);

        // A full period of increments returns to 0 with a single wrap on the last.
        do_reset();
        for (int i = 0; i < STEPS; i++) begin
            issue(0, 1'b1);
            wait_idle(0);
        end
        chk("full period phase_pos", 32'(pos0), 0);
        chk("full period shift_count", 32'(cnt0), STEPS);

        // Decrement from 0 wraps down, increment from the top wraps up.
        do_reset();
        issue(0, 1'b0);
        wait_idle(0);
        issue(0, 1'b1);
        wait_idle(0);

        // Overlapping requests mid-shift and in the ps_done cycle.
        do_reset();
        c = cyc;
        issue(0, 1'b1);
        while (cyc < c + 4) tick();
        poke(0, 1'b0);
        @(negedge clk);
        chk("overlap mid-busy sets err", 32'(err0), 1);
        tick();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        @(negedge clk);
        chk("err_clr clears err", 32'(err0), 0);
        while (cyc < c + DL0) tick();
        chk("ps_done cycle reached", 32'(if0.ps_done), 1);
        poke(0, 1'b0);
        @(negedge clk);
        chk("overlap in done cycle sets err", 32'(err0), 1);
        tick();
        wait_idle(0);
        chk("overlap keeps direction", 32'(pos0), 1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        @(negedge clk);
        chk("idle err_clr", 32'(err0), 0);
        tick();
        issue(0, 1'b1);
        tick();
        clr0 = 1'b1;
        poke(0, 1'b1);
        clr0 = 1'b0;
        @(negedge clk);
        chk("set beats clear", 32'(err0), 1);
        tick();
        wait_idle(0);
        chk("two shifts phase_pos", 32'(pos0), 2);

        // Asynchronous reset with the counter at 6 discards the pending shift.
        c = cyc;
        issue(0, 1'b1);
        while (cyc < c + 6) tick();
        rst_n = 1'b0;
        #1;
        chk("async reset ps_busy", 32'(if0.ps_busy), 0);
        chk("async reset ps_done", 32'(if0.ps_done), 0);
        chk("async reset phase_pos", 32'(pos0), 0);
        chk("async reset shift_count", 32'(cnt0), 0);
        chk("async reset err_overlap", 32'(err0), 0);
        q0.delete();
        m_pos[0] = 0; m_pos[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        issue(0, 1'b1);
        wait_idle(0);

        // Two-cycle latency instance.
        do_reset();
        r = cyc;
        while (cyc < r + 3) tick();
        issue(1, 1'b1);
        wait_idle(1);
        do_reset();
        for (int i = 0; i < 100; i++) begin
            issue(1, (i % 2) == 0);
            wait_idle(1);
        end
        chk("dut1 alternating phase_pos", 32'(pos1), 0);
        chk("dut1 alternating shift_count", 32'(cnt1), 100);
        chk("dut1 no overlap error", 32'(err1), 0);

        repeat (5) tick();
        chk("dut0 leftover expectations", q0.size(), 0);
        chk("dut1 leftover expectations", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmcm_ps_responder.md
Name: mmcm_ps_responder

Overview:
- Synthesizable responder for the MMCM dynamic phase-shift handshake (PSEN/PSINCDEC/PSDONE).
- Stands in for the MMCM so the fine-delay phase-shift controller can be simulated and hardware-looped without a real MMCM.
- Tracks the accumulated phase position modulo one output-clock period and flags initiator protocol violations.

Parameters:
- DONE_LATENCY, 12, PSCLK cycles from the accepted ps_en edge to the ps_done pulse; legal range 2..255.
- PERIOD_STEPS, 1176, phase steps per output period (56 steps/VCO period × divide 21); legal range ≥2.
- POS_W, 11, width of phase_pos; must satisfy 2^POS_W ≥ PERIOD_STEPS.

Ports:
- clk  in  1  PSCLK; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps_en  in  1  phase-shift request, one-cycle pulse from the initiator.
- ps_incdec  in  1  1 = increment, 0 = decrement; sampled with ps_en.
- ps_done  out  1  one-cycle completion pulse.
- ps_busy  out  1  high from the cycle after acceptance through the ps_done cycle, inclusive.
- phase_pos  out  POS_W  current position, 0..PERIOD_STEPS-1.
- wrap  out  1  one-cycle pulse when phase_pos wraps in either direction.
- err_overlap  out  1  sticky; set when ps_en arrives while busy.
- err_clr  in  1  synchronous clear of err_overlap.
- shift_count  out  16  count of completed shifts; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; latency counter 0. Any pending shift is discarded with no ps_done.
- FSM states:
  - IDLE: ps_en=1 → latch ps_incdec, load cnt = DONE_LATENCY-1, go to BUSY.
  - BUSY: cnt decrements every cycle. When cnt=1, ps_done is registered high for the next cycle, and the state goes to DONE.
  - DONE: ps_done=1 for exactly one cycle; then return to IDLE.
- Latency: ps_en sampled at edge N → ps_done high during cycle N+DONE_LATENCY, i.e. DONE_LATENCY cycles after the request cycle.
- The earliest next acceptance is the cycle after ps_done.
- phase_pos, shift_count and wrap all update on the same edge that raises ps_done, so they are visible coincident with ps_done.
- Increment: at PERIOD_STEPS-1 → 0 with wrap=1; otherwise +1.
- Decrement: at 0 → PERIOD_STEPS-1 with wrap=1; otherwise -1.
- ps_en while BUSY or DONE (including the ps_done cycle itself):
  - request ignored; no extra ps_done;
  - latched direction unchanged;
  - err_overlap set the next cycle.
- err_clr and a new overlap in the same cycle: set wins (err_overlap stays 1).
- ps_incdec is ignored when ps_en=0.
- phase_pos arithmetic is done in POS_W+1 bits before the wrap compare; no reliance on natural overflow.

Decomposition:
- delay_pkg gets:
  - PS_STEPS_PER_VCO = 56
  - PS_DONE_LATENCY_DEFAULT = 12
  - ps_resp_state_t enum {PSR_IDLE, PSR_BUSY, PSR_DONE}
- Single module, no sub-module. The latency counter and position accumulator are small enough to stay inline.

Test Plan:
- Reset, then one ps_en with incdec=1 at cycle 5 → ps_done high only in cycle 17, phase_pos=1, shift_count=1, ps_busy high cycles 6..17.
- 1176 back-to-back increments, each issued the cycle after ps_done → final phase_pos=0; wrap pulses exactly once, coincident with the 1176th ps_done.
- From reset, one decrement → phase_pos=1175 with wrap=1; then one increment → phase_pos=0 with wrap=1.
- ps_en at acceptance+4 and again in the ps_done cycle → one ps_done only, phase_pos=1, err_overlap=1. A later err_clr → 0; err_clr coincident with a fresh overlap → stays 1.
- Assert rst_n=0 mid-BUSY (cnt=6) → outputs 0 immediately (asynchronous); no ps_done after release; next request completes normally with 12-cycle latency.
- DONE_LATENCY=2 instance: ps_en at cycle 3 → ps_done in cycle 5; alternating inc/dec × 100 → phase_pos=0, shift_count=100, no err_overlap.
